sd_fifo_rd_arb: RTL and testbench
=================================

# sd_fifo_rd_arb

Read-port arbiter for a single memory shared by `channels` FIFO tail controllers, each confined to its own address window by its bound inputs. Each cycle it drives at most one tail's `enable`, muxes that tail's read pointer and `mem_re` onto the single memory read port, and records which channel owns the read data returning one cycle later. Read data is broadcast to all tails; each tail captures only on its own registered `prev_re`. The arbiter is round-robin with a bounded burst length, and channels stalled by output back-pressure release the port.

## Interface
- `channels`, 4: number of tail controllers, ≥2.
- `asz`, 8: memory address width, matching the tails' `asz`.
- `max_burst`, 4: maximum consecutive reads granted to one channel, ≥1.
- `csz`, `$clog2(channels)`: channel index width.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `t_usage`  in  channels*(asz+1)  per-tail `usage`; channel i occupies bits [i*(asz+1) +: asz+1].
- `t_rdptr`  in  channels*asz  per-tail `cur_rdptr`; channel i occupies bits [i*asz +: asz].
- `t_mem_re`  in  channels  per-tail `mem_re`.
- `t_enable`  out  channels  per-tail `enable`; one-hot or zero.
- `mem_re`  out  1  memory read enable.
- `mem_addr`  out  asz  memory read address.
- `rd_owner`  out  csz  channel whose read data is on the memory output this cycle.
- `rd_owner_vld`  out  1  `rd_owner` is valid.
- `err`  out  1  sticky protocol error.

## Operation
- Request: `req[i] = (t_usage[i] != 0)`.
- Registered state:
  - `owner` (csz), reset 0.
  - `own_vld` (1), reset 0.
  - `burst_cnt` (`$clog2(max_burst)+1` bits), reset 0.
  - `prio` (csz), reset 0: highest-priority index for the next fresh arbitration.
- Grant selection, combinational:
  - Keep: if `own_vld & req[owner] & burst_cnt < max_burst`, grant `owner`.
  - Otherwise: grant the first `i` with `req[i]`, scanning `prio`, `prio+1`, … modulo `channels`. Wrap is modulo `channels`, not a power of 2.
  - Otherwise: no grant.
- Outputs, combinational:
  - `t_enable = onehot(grant)`, or 0 when there is no grant.
  - `mem_re = |(t_mem_re & t_enable)`.
  - `mem_addr = t_rdptr[grant]` when there is a grant; otherwise hold at 0.
- State update, in this priority order:
  - Granted and `t_mem_re[g]` (read issued):
    - `owner<=g`, `own_vld<=1`.
    - `burst_cnt <= (g==owner & own_vld) ? burst_cnt+1 : 1`.
    - Counter saturates at `max_burst`.
  - Granted, no `t_mem_re[g]` (tail back-pressured or aborting): `own_vld<=0`, `burst_cnt<=0`, `prio<=g+1 mod channels`.
  - Keep-rule fails because the burst is exhausted or `req[owner]` dropped: `prio<=owner+1 mod channels` on that arbitration cycle.
  - No grant: `own_vld<=0`, `burst_cnt<=0`.
- Read return:
  - `rd_owner_vld <= mem_re`.
  - `rd_owner <= g` when `mem_re`; otherwise `rd_owner` holds.
- Error: `err` is set when `t_mem_re & ~t_enable` is nonzero. It is cleared only by reset.
- No combinational loop: `t_mem_re` may depend on `t_enable`, but `grant` depends only on registered state and `t_usage`.

## Timing
- Reset values: `t_enable=0`, `mem_re=0`, `mem_addr=0`, `rd_owner=0`, `rd_owner_vld=0`, `err=0`.
- Grant latency: zero cycles. `t_enable` is valid in the same cycle `t_usage` becomes nonzero.
- Read data latency: `mem_addr` is sampled by the memory on the posedge after `mem_re`. `rd_owner` / `rd_owner_vld` align with the data, 1 cycle after `mem_re`.
- Throughput: one read per cycle, sustained across channel switches; there are no idle cycles between bursts.
- Empty: `usage==0` never receives a grant. A channel whose pointer wraps at `bound_high` is unaffected; the arbiter never interprets addresses.
- Full-burst boundary: after `max_burst` consecutive reads, the next cycle grants another requesting channel if one exists. If the owner is the only requester, the same owner is re-granted and `burst_cnt` restarts at 1.
- Simultaneous events: a stall and a new request on another channel in the same cycle → next cycle grants by the round-robin scan from `g+1`.
- Reset mid-burst: all state clears immediately (async). The in-flight `rd_owner_vld` is dropped; the tails' own resets discard their data.

## Test plan
- Single requester, `channels=4`, `max_burst=4`, `t_usage[1]=5`, tail always issues → `t_enable=4'b0010` for 5 cycles, `mem_addr` follows `t_rdptr[1]`, `rd_owner=1` with `rd_owner_vld` 1 cycle later each time.
- All 4 channels requesting continuously, `max_burst=2` → grant sequence 0,0,1,1,2,2,3,3,0,0…; `mem_re` high every cycle.
- Stall release: ch0 and ch2 requesting; ch0 granted with `t_mem_re[0]=0` → next cycle `t_enable=4'b0100`, `prio=1`.
- Mid-burst drop: ch3 owner with `burst_cnt=1`, `t_usage[3]` goes to 0 while ch1 requests → same cycle `t_enable=4'b0010`.
- Protocol error: force `t_mem_re[2]=1` while `t_enable=4'b0001` → `err=1` next cycle and stays 1 until reset.
- Reset mid-burst: assert `reset` during a ch1 burst → all outputs 0 asynchronously. After release, with ch1 and ch3 requesting, the first grant is ch1 (`prio=0` scan).

Source files
------------

// File: rtl/sd_fifo_rd_arb.sv
// sd_fifo_rd_arb: read-port arbiter for one memory shared by several FIFO tail controllers.
// Picks at most one tail per cycle (round-robin with a bounded burst length), muxes that
// tail's read pointer and mem_re onto the memory read port, and tags the data returning
// one cycle later with its owning channel.
//
// Ports:
//   clk           clock, state updates on posedge
//   reset         asynchronous active-high reset
//   t_usage       per-tail usage, channel i at [i*(asz+1) +: asz+1]; nonzero = request
//   t_rdptr       per-tail read pointer, channel i at [i*asz +: asz]
//   t_mem_re      per-tail memory read enable (may depend on t_enable)
//   t_enable      per-tail grant, one-hot or zero
//   mem_re        memory read enable
//   mem_addr      memory read address (0 when nothing is granted)
//   rd_owner      channel owning the read data on the memory output this cycle
//   rd_owner_vld  rd_owner is valid
//   err           sticky: a tail asserted mem_re without holding the grant
module sd_fifo_rd_arb #(
  parameter int unsigned channels  = 4,
  parameter int unsigned asz       = 8,
  parameter int unsigned max_burst = 4,
  parameter int unsigned csz       = $clog2(channels)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [channels*(asz+1)-1:0]   t_usage,
  input  logic [channels*asz-1:0]       t_rdptr,
  input  logic [channels-1:0]           t_mem_re,
  output logic [channels-1:0]           t_enable,
  output logic                          mem_re,
  output logic [asz-1:0]                mem_addr,
  output logic [csz-1:0]                rd_owner,
  output logic                          rd_owner_vld,
  output logic                          err
);

  localparam int unsigned BW = $clog2(max_burst) + 1;
  localparam logic [BW-1:0] MaxBurst = BW'(max_burst);

  // Increment a channel index, wrapping at channels (which need not be a power of 2).
  function automatic logic [csz-1:0] wrap_inc(input logic [csz-1:0] idx);
    if (32'(idx) + 32'd1 >= channels) return '0;
    else return idx + csz'(1);
  endfunction

  logic [csz-1:0] owner_q, owner_d;
  logic           own_vld_q, own_vld_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [csz-1:0] prio_q, prio_d;
  logic [csz-1:0] rd_owner_q;
  logic           rd_owner_vld_q;
  logic           err_q;

  logic [channels-1:0] req;
  logic                keep;
  logic [csz-1:0]      scan_start;
  logic                grant_vld;
  logic [csz-1:0]      grant;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < channels; i++) begin
      req[i] = |t_usage[i*(asz+1) +: (asz+1)];
    end
  end

  assign keep = own_vld_q & req[owner_q] & (burst_q < MaxBurst);

  // When the keep rule fails for a live owner, the fresh scan on that same cycle already
  // starts just past the owner, so a finished burst hands over with no idle cycle.
  assign scan_start = own_vld_q ? wrap_inc(owner_q) : prio_q;

  // Grant is a function of registered state and t_usage only, so tails may derive
  // t_mem_re from t_enable without forming a loop. Reset forces no grant.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    if (!reset) begin
      if (keep) begin
        grant_vld = 1'b1;
        grant     = owner_q;
      end else begin
        for (int unsigned k = 0; k < channels; k++) begin
          idx = 32'(scan_start) + k;
          if (idx >= channels) idx = idx - channels;
          if (!grant_vld && req[csz'(idx)]) begin
            grant_vld = 1'b1;
            grant     = csz'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    t_enable = '0;
    mem_addr = '0;
    for (int unsigned i = 0; i < channels; i++) begin
      if (grant_vld && (grant == csz'(i))) begin
        t_enable[i] = 1'b1;
        mem_addr    = t_rdptr[i*asz +: asz];
      end
    end
  end

  assign mem_re = |(t_mem_re & t_enable);

  always_comb begin
    owner_d   = owner_q;
    own_vld_d = own_vld_q;
    burst_d   = burst_q;
    prio_d    = prio_q;
    // Burst exhausted or owner's request dropped: rotate priority past the owner.
    if (own_vld_q && !keep) prio_d = wrap_inc(owner_q);
    if (grant_vld) begin
      if (t_mem_re[grant]) begin
        owner_d   = grant;
        own_vld_d = 1'b1;
        // keep implies burst_q < max_burst, so the increment cannot overflow.
        burst_d   = keep ? burst_q + BW'(1) : BW'(1);
      end else begin
        // Tail stalled: release the port and let the next channel go first.
        own_vld_d = 1'b0;
        burst_d   = '0;
        prio_d    = wrap_inc(grant);
      end
    end else begin
      own_vld_d = 1'b0;
      burst_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q        <= '0;
      own_vld_q      <= 1'b0;
      burst_q        <= '0;
      prio_q         <= '0;
      rd_owner_q     <= '0;
      rd_owner_vld_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      owner_q        <= owner_d;
      own_vld_q      <= own_vld_d;
      burst_q        <= burst_d;
      prio_q         <= prio_d;
      rd_owner_vld_q <= mem_re;
      if (mem_re) rd_owner_q <= grant;
      err_q          <= err_q | (|(t_mem_re & ~t_enable));
    end
  end

  assign rd_owner     = rd_owner_q;
  assign rd_owner_vld = rd_owner_vld_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sd_fifo_rd_arb.sv
// Directed bench for sd_fifo_rd_arb with channels=4, asz=8, max_burst=2.
module tb_sd_fifo_rd_arb;

  localparam int unsigned Ch  = 4;
  localparam int unsigned Asz = 8;
  localparam int unsigned Mb  = 2;
  localparam int unsigned Csz = 2;

  logic                    clk;
  logic                    reset;
  logic [Ch*(Asz+1)-1:0]   t_usage;
  logic [Ch*Asz-1:0]       t_rdptr;
  logic [Ch-1:0]           t_mem_re;
  logic [Ch-1:0]           t_enable;
  logic                    mem_re;
  logic [Asz-1:0]          mem_addr;
  logic [Csz-1:0]          rd_owner;
  logic                    rd_owner_vld;
  logic                    err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  sd_fifo_rd_arb #(
    .channels (Ch),
    .asz      (Asz),
    .max_burst(Mb)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .t_usage     (t_usage),
    .t_rdptr     (t_rdptr),
    .t_mem_re    (t_mem_re),
    .t_enable    (t_enable),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .rd_owner    (rd_owner),
    .rd_owner_vld(rd_owner_vld),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_usage(input int ch, input int val);
    logic [Asz:0] v;
    v = val[Asz:0];
    t_usage[ch*(Asz+1) +: (Asz+1)] = v;
  endtask

  task automatic set_ptr(input int ch, input int val);
    logic [Asz-1:0] v;
    v = val[Asz-1:0];
    t_rdptr[ch*Asz +: Asz] = v;
  endtask

  initial begin
    int seq[10];
    reset    = 1'b1;
    t_usage  = '0;
    t_rdptr  = '0;
    t_mem_re = '0;
    #2;
    check("rst_enable", 32'(t_enable), 32'h0);
    check("rst_mem_re", 32'(mem_re), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_owner", 32'(rd_owner), 32'h0);
    check("rst_vld", 32'(rd_owner_vld), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    tick();
    reset = 1'b0;

    // Single requester ch1, tail always issues; burst boundary re-grants ch1.
    for (int k = 0; k < 5; k++) begin
      set_ptr(1, 8'h10 + k);
      set_usage(1, 5 - k);
      t_mem_re = 4'b0010;
      #1;
      check("single_enable", 32'(t_enable), 32'h2);
      check("single_addr", 32'(mem_addr), 32'h10 + k);
      check("single_mem_re", 32'(mem_re), 32'h1);
      tick();
      check("single_vld", 32'(rd_owner_vld), 32'h1);
      check("single_owner", 32'(rd_owner), 32'h1);
    end
    set_usage(1, 0);
    t_mem_re = 4'b0000;
    #1;
    check("empty_enable", 32'(t_enable), 32'h0);
    check("empty_addr", 32'(mem_addr), 32'h0);
    check("empty_mem_re", 32'(mem_re), 32'h0);
    tick();
    check("empty_vld", 32'(rd_owner_vld), 32'h0);
    check("empty_owner_hold", 32'(rd_owner), 32'h1);

    // All four requesting; priority sits at 2 after the ch1 burst ended.
    for (int i = 0; i < 4; i++) begin
      set_usage(i, 3);
      set_ptr(i, 8'hA0 + i);
    end
    seq = '{2, 2, 3, 3, 0, 0, 1, 1, 2, 2};
    for (int k = 0; k < 10; k++) begin
      t_mem_re = 4'(1 << seq[k]);
      #1;
      check("rr_enable", 32'(t_enable), 32'(1 << seq[k]));
      check("rr_addr", 32'(mem_addr), 32'hA0 + 32'(seq[k]));
      check("rr_mem_re", 32'(mem_re), 32'h1);
      tick();
      check("rr_owner", 32'(rd_owner), 32'(seq[k]));
      check("rr_vld", 32'(rd_owner_vld), 32'h1);
    end
    for (int i = 0; i < 4; i++) set_usage(i, 0);
    t_mem_re = 4'b0000;
    tick();
    check("idle_vld", 32'(rd_owner_vld), 32'h0);

    // Stall release: ch0 granted (scan from 3) but does not issue; ch2 follows.
    set_usage(0, 1);
    set_usage(2, 1);
    #1;
    check("stall_enable", 32'(t_enable), 32'h1);
    check("stall_mem_re", 32'(mem_re), 32'h0);
    tick();
    check("stall_vld", 32'(rd_owner_vld), 32'h0);
    t_mem_re = 4'b0100;
    #1;
    check("release_enable", 32'(t_enable), 32'h4);
    check("release_addr", 32'(mem_addr), 32'hA2);
    check("release_mem_re", 32'(mem_re), 32'h1);
    tick();
    check("release_owner", 32'(rd_owner), 32'h2);

    // Mid-burst drop: ch3 becomes owner, then drops while ch1 requests.
    set_usage(0, 0);
    set_usage(2, 0);
    set_usage(3, 4);
    t_mem_re = 4'b1000;
    #1;
    check("ch3_enable", 32'(t_enable), 32'h8);
    check("ch3_addr", 32'(mem_addr), 32'hA3);
    tick();
    check("ch3_owner", 32'(rd_owner), 32'h3);
    set_usage(3, 0);
    set_usage(1, 2);
    t_mem_re = 4'b0010;
    #1;
    check("drop_enable", 32'(t_enable), 32'h2);
    check("drop_addr", 32'(mem_addr), 32'hA1);
    tick();
    check("drop_owner", 32'(rd_owner), 32'h1);

    // Protocol error: ch2 raises mem_re while only ch0 holds the grant.
    set_usage(1, 0);
    set_usage(0, 2);
    t_mem_re = 4'b0101;
    #1;
    check("err_enable", 32'(t_enable), 32'h1);
    check("err_before", 32'(err), 32'h0);
    tick();
    check("err_set", 32'(err), 32'h1);
    set_usage(0, 0);
    t_mem_re = 4'b0000;
    tick();
    tick();
    check("err_sticky", 32'(err), 32'h1);

    // Reset in the middle of a ch1 burst.
    set_usage(1, 3);
    t_mem_re = 4'b0010;
    #1;
    check("burst_enable", 32'(t_enable), 32'h2);
    tick();
    check("burst_vld", 32'(rd_owner_vld), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_enable", 32'(t_enable), 32'h0);
    check("arst_mem_re", 32'(mem_re), 32'h0);
    check("arst_addr", 32'(mem_addr), 32'h0);
    check("arst_owner", 32'(rd_owner), 32'h0);
    check("arst_vld", 32'(rd_owner_vld), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    set_usage(3, 3);
    reset = 1'b0;
    #1;
    check("post_rst_enable", 32'(t_enable), 32'h2);
    check("post_rst_addr", 32'(mem_addr), 32'hA1);
    tick();
    check("post_rst_owner", 32'(rd_owner), 32'h1);
    check("post_rst_vld", 32'(rd_owner_vld), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
